// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared FSM state type and bit-timer width for the UART receive monitor (UART_RX_PARITY_EN adds the PARITY state)
package uart_rx_pkg;

    localparam int TIMER_W = 16;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } rx_state_e;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO with power-of-two depth, registered pointers and drop-on-full indication
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             empty, do_pop, do_push;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign valid_o = !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO alongside a pop is accepted.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !pop_i;
    // Head is forced to zero while empty so the output is defined out of reset.
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array write; contents are don't-care while not covered by count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - UART receiver with synchronizer, framing FSM, receive FIFO and sticky errors; UART_RX_PARITY_EN enables the parity bit
module uart_rx_monitor
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 core_clk,
    input  logic                 core_rstn,
    input  logic                 ser_rx,
    input  logic                 rd_en,
    input  logic                 err_clr,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [3:0]         LAST_BIT  = 4'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_wait_q;
    logic                 bit_tick;
    logic                 stop_sample;
    logic                 push;
    logic                 frame_evt;
    logic                 drop;
    logic                 overflow_q, overflow_d;
    logic                 frame_err_q, frame_err_d;

    assign rx_s        = sync_q[1];
    assign bit_tick    = (timer_q == '0);
    assign stop_sample = (state_q == ST_STOP) && !stop_wait_q && bit_tick;
    assign frame_evt   = stop_sample && !rx_s;
    assign busy        = (state_q != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
    logic parity_evt;
    logic parity_err_q, parity_err_d;
    logic par_mismatch;

    // Received parity bit must equal the data XOR plus one for odd parity.
    assign par_mismatch = rx_s != ((^shift_q) ^ parity_odd);
    assign parity_evt   = (state_q == ST_PARITY) && bit_tick && par_mismatch;
    assign push         = stop_sample && rx_s && !par_bad_q;
`else
    assign push         = stop_sample && rx_s;
`endif

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ser_rx};
        end
    end

    // Framing FSM: bit timer reloads on each state entry and counts down to the sample point.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q     <= ST_START;
                        timer_q     <= HALF_LOAD;
                        stop_wait_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_bad_q   <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        if (!rx_s) begin
                            state_q   <= ST_DATA;
                            timer_q   <= BIT_LOAD;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        timer_q <= BIT_LOAD;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        par_bad_q <= par_mismatch;
                        state_q   <= ST_STOP;
                        timer_q   <= BIT_LOAD;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (stop_wait_q) begin
                        // After a bad stop bit, hold here until the line idles so the
                        // remaining low level is not mistaken for a new start bit.
                        if (rx_s) begin
                            state_q     <= ST_IDLE;
                            stop_wait_q <= 1'b0;
                        end
                    end else if (bit_tick) begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            stop_wait_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a new event outranks a simultaneous clear.
    always_comb begin
        overflow_d  = drop      | (overflow_q  & ~err_clr);
        frame_err_d = frame_evt | (frame_err_q & ~err_clr);
    end

    // Sticky flag registers.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity flag next-state with the same event-wins rule.
    always_comb begin
        parity_err_d = parity_evt | (parity_err_q & ~err_clr);
    end

    // Parity flag register.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (core_clk),
        .rstn_i  (core_rstn),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (rd_en),
        .data_o  (rd_data),
        .valid_o (rd_valid),
        .full_o  (fifo_full),
        .drop_o  (drop)
    );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - scoreboard bench for uart_rx_monitor at 16 clocks per bit (parity scenario built with UART_RX_PARITY_EN)
module tb_uart_rx_monitor;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int FD  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int NB       = DB + PB + 2;
    // 2 synchronizer flops + 1 IDLE detect, half a bit in START, then data, parity and stop bits.
    localparam int STOP_OFS = 3 + CPB / 2 + CPB * (DB + PB + 1);

    logic          core_clk = 1'b0;
    logic          core_rstn;
    logic          ser_rx;
    logic          rd_en;
    logic          err_clr;
    logic          parity_odd;
    logic [DB-1:0] rd_data;
    logic          rd_valid;
    logic          fifo_full;
    logic          overflow;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    exp_q[$];

    uart_rx_monitor #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .core_clk   (core_clk),
        .core_rstn  (core_rstn),
        .ser_rx     (ser_rx),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one frame from a negedge; reports the cycle offset at which rd_valid rose
    // and optionally pulses rd_en / err_clr over the stop-sample edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_bit,
                              input logic pop_stop, input logic clr_stop,
                              output int rise_k, output logic [7:0] popped);
        logic prev;
        int   b;
        rise_k = -1;
        popped = 8'h00;
        @(negedge core_clk);
        prev = rd_valid;
        for (int k = 0; k < NB * CPB; k++) begin
            b = k / CPB;
            if (b == 0)                    ser_rx = 1'b0;
            else if (b <= DB)              ser_rx = data[b-1];
            else if (PB == 1 && b == DB+1) ser_rx = par_bit;
            else                           ser_rx = stop_val;
            rd_en   = pop_stop && (k == STOP_OFS - 1);
            err_clr = clr_stop && (k == STOP_OFS - 1);
            if (rd_en) popped = rd_data;
            @(negedge core_clk);
            if (rd_valid && !prev && rise_k < 0) rise_k = k + 1;
            prev = rd_valid;
        end
        ser_rx  = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (4) @(negedge core_clk);
    endtask

    task automatic test_reset();
        core_rstn = 1'b0;
        repeat (3) @(negedge core_clk);
        checks++;
        if ({busy, rd_valid, fifo_full, overflow, frame_err, parity_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy, rd_valid, fifo_full, overflow, frame_err, parity_err});
        end
        checks++;
        if (rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=00", rd_data);
        end
        core_rstn = 1'b1;
        repeat (4) @(negedge core_clk);
    endtask

    task automatic test_basic();
        logic [7:0] pats [4] = '{8'h55, 8'h00, 8'hFF, 8'h81};
        logic [7:0] exp, pop_v;
        int         rk;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pats[i]);
            send_frame(pats[i], 1'b1, ^pats[i], 1'b0, 1'b0, rk, pop_v);
            checks++;
            if (rk !== STOP_OFS) begin
                failures++;
                $display("FAIL basic_latency[%0h] got=%0d exp=%0d", pats[i], rk, STOP_OFS);
            end
            checks++;
            if ({overflow, frame_err, parity_err} !== 3'b0) begin
                failures++;
                $display("FAIL basic_flags[%0h] got=%b exp=000", pats[i], {overflow, frame_err, parity_err});
            end
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                failures++;
                $display("FAIL basic_data got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
            end
            rd_en = 1'b1;
            @(negedge core_clk);
            rd_en = 1'b0;
            checks++;
            if (rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_empty_after_pop got=%b exp=0", rd_valid);
            end
        end
    endtask

    task automatic test_glitch();
        ser_rx = 1'b0;
        repeat (4) @(negedge core_clk);
        ser_rx = 1'b1;
        @(negedge core_clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start got=%b exp=1", busy);
        end
        repeat (15) @(negedge core_clk);
        checks++;
        if ({busy, rd_valid, overflow, frame_err, parity_err} !== 5'b0) begin
            failures++;
            $display("FAIL glitch_idle got=%b exp=00000", {busy, rd_valid, overflow, frame_err, parity_err});
        end
    endtask

    task automatic test_frame_err();
        int         rk;
        logic [7:0] pop_v;
        // err_clr lands on the bad stop-sample edge; the error must still be recorded.
        send_frame(8'hA3, 1'b0, ^8'hA3, 1'b0, 1'b1, rk, pop_v);
        checks++;
        if ({frame_err, rd_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL frame_err_set got=%b exp=100", {frame_err, rd_valid, busy});
        end
        err_clr = 1'b1;
        @(negedge core_clk);
        err_clr = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_clear got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_overflow();
        int         rk;
        logic [7:0] pop_v, exp;
        for (int i = 0; i < 9; i++) begin
            if (i < FD) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, ^(8'(i)), 1'b0, 1'b0, rk, pop_v);
            if (i == FD - 1) begin
                checks++;
                if ({fifo_full, overflow} !== 2'b10) begin
                    failures++;
                    $display("FAIL ovf_exact_full got=%b exp=10", {fifo_full, overflow});
                end
            end
        end
        checks++;
        if ({fifo_full, overflow} !== 2'b11) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=11", {fifo_full, overflow});
        end
        for (int i = 0; i < FD; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                failures++;
                $display("FAIL ovf_pop[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp);
            end
            rd_en = 1'b1;
            @(negedge core_clk);
            rd_en = 1'b0;
        end
        err_clr = 1'b1;
        @(negedge core_clk);
        err_clr = 1'b0;
        checks++;
        if ({rd_valid, fifo_full, overflow} !== 3'b000) begin
            failures++;
            $display("FAIL ovf_drained got=%b exp=000", {rd_valid, fifo_full, overflow});
        end
    endtask

    task automatic test_full_push_pop();
        int         rk;
        logic [7:0] pop_v, exp;
        for (int i = 0; i < FD; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1, ^(8'h10 + 8'(i)), 1'b0, 1'b0, rk, pop_v);
        end
        exp_q.push_back(8'h18);
        send_frame(8'h18, 1'b1, ^8'h18, 1'b1, 1'b0, rk, pop_v);
        exp = exp_q.pop_front();
        checks++;
        if (pop_v !== exp) begin
            failures++;
            $display("FAIL fpp_head got=%h exp=%h", pop_v, exp);
        end
        checks++;
        if ({fifo_full, overflow} !== 2'b10) begin
            failures++;
            $display("FAIL fpp_no_overflow got=%b exp=10", {fifo_full, overflow});
        end
        for (int i = 0; i < FD; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                failures++;
                $display("FAIL fpp_pop[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp);
            end
            rd_en = 1'b1;
            @(negedge core_clk);
            rd_en = 1'b0;
        end
        rd_en = 1'b1;
        @(negedge core_clk);
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, fifo_full} !== 2'b00) begin
            failures++;
            $display("FAIL empty_pop_ignored got=%b exp=00", {rd_valid, fifo_full});
        end
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, 1'b0, rk, pop_v);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            failures++;
            $display("FAIL wrap_data got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
        end
        rd_en = 1'b1;
        @(negedge core_clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h3C;
        logic [7:0] pop_v, exp;
        int         rk;
        ser_rx = 1'b0;
        repeat (CPB) @(negedge core_clk);
        for (int b = 0; b < 2; b++) begin
            ser_rx = d[b];
            repeat (CPB) @(negedge core_clk);
        end
        ser_rx = d[2];
        repeat (CPB / 2) @(negedge core_clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_before got=%b exp=1", busy);
        end
        core_rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy_async got=%b exp=0", busy);
        end
        ser_rx = 1'b1;
        repeat (3) @(negedge core_clk);
        core_rstn = 1'b1;
        repeat (2 * CPB) @(negedge core_clk);
        checks++;
        if ({busy, rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL mid_after_release got=%b exp=00", {busy, rd_valid});
        end
        exp_q.push_back(d);
        send_frame(d, 1'b1, ^d, 1'b0, 1'b0, rk, pop_v);
        exp = exp_q.pop_front();
        checks++;
        if (rk !== STOP_OFS || rd_data !== exp) begin
            failures++;
            $display("FAIL mid_resume got=%0d/%h exp=%0d/%h", rk, rd_data, STOP_OFS, exp);
        end
        rd_en = 1'b1;
        @(negedge core_clk);
        rd_en = 1'b0;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] pop_v, exp;
        int         rk;
        parity_odd = 1'b1;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, rk, pop_v);
        checks++;
        if ({parity_err, rd_valid} !== 2'b10) begin
            failures++;
            $display("FAIL parity_bad got=%b exp=10", {parity_err, rd_valid});
        end
        err_clr = 1'b1;
        @(negedge core_clk);
        err_clr = 1'b0;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, rk, pop_v);
        exp = exp_q.pop_front();
        checks++;
        if ({parity_err, rd_valid} !== 2'b01 || rd_data !== exp) begin
            failures++;
            $display("FAIL parity_good got=%b/%h exp=01/%h", {parity_err, rd_valid}, rd_data, exp);
        end
        rd_en = 1'b1;
        @(negedge core_clk);
        rd_en = 1'b0;
        parity_odd = 1'b0;
    endtask
`endif

    initial begin
        core_rstn  = 1'b0;
        ser_rx     = 1'b1;
        rd_en      = 1'b0;
        err_clr    = 1'b0;
        parity_odd = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4167, meaning core_clk cycles per bit (range 8..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (range 5..9).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of 2, range 2..64).
REQ-004 The block SHALL have port core_clk, input, width 1: the single clock; it is the only clock.
REQ-005 The block SHALL have port core_rstn, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port ser_rx, input, width 1: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rd_en, input, width 1: pop the FIFO head.
REQ-008 The block SHALL have port err_clr, input, width 1: clear all sticky error flags.
REQ-009 The block SHALL have port parity_odd, input, width 1: 1 selects odd parity, 0 selects even parity; this port exists only with UART_RX_PARITY_EN.
REQ-010 The block SHALL have port rd_data, output, width DATA_BITS: the FIFO head.
REQ-011 The block SHALL have port rd_valid, output, width 1: FIFO not empty.
REQ-012 The block SHALL have port fifo_full, output, width 1: FIFO full.
REQ-013 The block SHALL have ports overflow, frame_err and parity_err, each output, width 1: sticky error flags.
REQ-014 The block SHALL have port busy, output, width 1: a frame is in progress (state not IDLE).

Function
REQ-015 ser_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and a 16-bit bit-timer that reloads on every state entry.
REQ-017 IDLE SHALL move to START on the first cycle the synchronized line reads 0.
REQ-018 START SHALL wait CLKS_PER_BIT/2 cycles, then sample: 0 moves to DATA; 1 is a glitch and returns to IDLE with no flag set.
REQ-019 DATA SHALL sample every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples, then move to PARITY (with macro) or STOP (without macro).
REQ-020 PARITY SHALL sample one bit after CLKS_PER_BIT cycles and flag a mismatch against parity_odd; STOP follows.
REQ-021 STOP SHALL sample after CLKS_PER_BIT cycles: 1 pushes the frame unless a parity mismatch occurred (a mismatched frame is dropped and parity_err set); 0 drops the frame, sets frame_err, and waits for the line to return to 1 before entering IDLE.
REQ-022 rd_valid SHALL rise the cycle after the accepting STOP sample (latency 1).
REQ-023 A push when full and rd_en is 0 SHALL drop the frame and set overflow.
REQ-024 Simultaneous push and pop when full SHALL accept both with no overflow.
REQ-025 rd_en while empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 When err_clr coincides with a new error event, the error SHALL win (flag reads 1 next cycle).

Reset
REQ-027 core_rstn low SHALL asynchronously force: FSM to IDLE, FIFO to empty, and sticky flags, busy, fifo_full and rd_valid to 0; rd_data SHALL be 0; synchronizer flops SHALL be 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only at the next falling edge.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL control the parity feature.
REQ-030 With UART_RX_PARITY_EN defined, the frame SHALL include one parity bit, the parity_odd port SHALL exist, and parity_err SHALL be live.
REQ-031 With UART_RX_PARITY_EN undefined, there SHALL be no PARITY state and no parity_odd port, and parity_err SHALL be tied to 0.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the FSM state typedef and the bit-timer width constant.
REQ-033 The FIFO SHALL be a sub-module, uart_rx_fifo, parametrised by width and depth.

Verification (bench with CLKS_PER_BIT=16)
REQ-034 Sending 0x55, 8N1, 16 clocks/bit SHALL give rd_valid=1 and rd_data=0x55 one cycle after the stop sample, with no flags set.
REQ-035 A 4-cycle low pulse on ser_rx SHALL return the FSM to IDLE with rd_valid=0 and no flags set.
REQ-036 Sending 0xA3 with the stop bit held 0 SHALL set frame_err=1 with the FIFO still empty; a subsequent err_clr pulse SHALL clear it.
REQ-037 Nine frames (0x00..0x08) with FIFO_DEPTH=8 and no reads SHALL set overflow=1, fifo_full=1, and pops SHALL return 0x00..0x07.
REQ-038 With the macro defined and parity_odd=1, frame 0x01 with parity bit 1 SHALL set parity_err=1 and push nothing; the same frame with parity bit 0 SHALL be pushed.
REQ-039 Asserting core_rstn low in the middle of a DATA bit SHALL give busy=0 immediately; the next clean 0x3C frame SHALL be received correctly.
